// File: rtl/mips_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mips_wb_arbiter
// Description : Round-robin write-back arbiter sharing two register-file write
//               ports among ALU0, ALU1, MEM and MUL/DIV, with a stall counter.
// Revision    : 1.0 - initial release
// ============================================================================
module mips_wb_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 5,
    parameter int DATA_W  = 32,
    parameter int CNT_W   = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] req_reg,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic                      wb_hold,
    output logic [ADDR_W-1:0]         write_reg_1,
    output logic [DATA_W-1:0]         write_data_1,
    output logic                      signal_reg_write_1,
    output logic [ADDR_W-1:0]         write_reg_2,
    output logic [DATA_W-1:0]         write_data_2,
    output logic                      signal_reg_write_2,
    output logic [CNT_W-1:0]          stall_cnt
);

    logic [1:0]         r_rr_ptr;
    logic               w_open;
    logic [5:0]         w_grant;
    logic               w_v1;
    logic               w_v2;
    logic [1:0]         w_i1;
    logic [1:0]         w_i2;
    logic               w_stall;
    logic [5:0]         w_probe [NUM_REQ];

    // Returns {port1 valid, port1 index, port2 valid, port2 index}.
    function automatic logic [5:0] arbitrate(
        input logic [NUM_REQ-1:0]        vld,
        input logic [NUM_REQ*ADDR_W-1:0] regs,
        input logic [1:0]                ptr
    );
        logic              v1;
        logic              v2;
        logic [1:0]        i1;
        logic [1:0]        i2;
        logic [1:0]        idx;
        logic [ADDR_W-1:0] r;
        logic [ADDR_W-1:0] r1;
        v1 = 1'b0;
        v2 = 1'b0;
        i1 = 2'd0;
        i2 = 2'd0;
        r1 = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = ptr + 2'(k);
            r   = regs[int'(idx)*ADDR_W +: ADDR_W];
            if (vld[idx] && (r != '0)) begin
                if (!v1) begin
                    v1 = 1'b1;
                    i1 = idx;
                    r1 = r;
                end else if (!v2 && (r != r1)) begin
                    v2 = 1'b1;
                    i2 = idx;
                end
            end
        end
        return {v1, i1, v2, i2};
    endfunction

    assign w_open  = !wb_hold && !rst;
    assign w_grant = arbitrate(req_valid & {NUM_REQ{w_open}}, req_reg, r_rr_ptr);
    assign w_v1    = w_grant[5];
    assign w_i1    = w_grant[4:3];
    assign w_v2    = w_grant[2];
    assign w_i2    = w_grant[1:0];

    // Each ready is evaluated as if its own valid were set, keeping ready
    // independent of that producer's valid.
    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_probe[i]   = arbitrate((req_valid | (NUM_REQ'(1) << i)) & {NUM_REQ{w_open}},
                                     req_reg, r_rr_ptr);
            req_ready[i] = w_open &&
                           ((req_reg[i*ADDR_W +: ADDR_W] == '0) ||
                            (w_probe[i][5] && (w_probe[i][4:3] == 2'(i))) ||
                            (w_probe[i][2] && (w_probe[i][1:0] == 2'(i))));
        end
    end

    assign w_stall = |(req_valid & ~req_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr           <= 2'd0;
            stall_cnt          <= '0;
            signal_reg_write_1 <= 1'b0;
            signal_reg_write_2 <= 1'b0;
            write_reg_1        <= '0;
            write_reg_2        <= '0;
            write_data_1       <= '0;
            write_data_2       <= '0;
        end else begin
            signal_reg_write_1 <= w_v1;
            signal_reg_write_2 <= w_v2;
            if (w_v1) begin
                write_reg_1  <= req_reg[int'(w_i1)*ADDR_W +: ADDR_W];
                write_data_1 <= req_data[int'(w_i1)*DATA_W +: DATA_W];
            end
            if (w_v2) begin
                write_reg_2  <= req_reg[int'(w_i2)*ADDR_W +: ADDR_W];
                write_data_2 <= req_data[int'(w_i2)*DATA_W +: DATA_W];
            end
            if (w_v2) begin
                r_rr_ptr <= w_i2 + 2'd1;
            end else if (w_v1) begin
                r_rr_ptr <= w_i1 + 2'd1;
            end
            if (w_stall && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mips_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mips_wb_arbiter
// Description : Directed and randomized bench for mips_wb_arbiter against a
//               scan-list reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mips_wb_arbiter;

    localparam int NUM_REQ = 4;
    localparam int ADDR_W  = 5;
    localparam int DATA_W  = 32;
    localparam int CNT_W   = 16;
    localparam int SAT     = (1 << CNT_W) - 1;

    logic                      clk = 1'b0;
    logic                      rst;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*ADDR_W-1:0] req_reg;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      wb_hold;
    logic [ADDR_W-1:0]         write_reg_1;
    logic [DATA_W-1:0]         write_data_1;
    logic                      signal_reg_write_1;
    logic [ADDR_W-1:0]         write_reg_2;
    logic [DATA_W-1:0]         write_data_2;
    logic                      signal_reg_write_2;
    logic [CNT_W-1:0]          stall_cnt;

    logic [ADDR_W-1:0] rg [NUM_REQ];
    logic [DATA_W-1:0] dt [NUM_REQ];

    assign req_reg  = {rg[3], rg[2], rg[1], rg[0]};
    assign req_data = {dt[3], dt[2], dt[1], dt[0]};

    mips_wb_arbiter #(
        .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_reg(req_reg),
        .req_data(req_data), .req_ready(req_ready), .wb_hold(wb_hold),
        .write_reg_1(write_reg_1), .write_data_1(write_data_1),
        .signal_reg_write_1(signal_reg_write_1),
        .write_reg_2(write_reg_2), .write_data_2(write_data_2),
        .signal_reg_write_2(signal_reg_write_2), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model state
    int  m_ptr;
    int  m_stall;
    bit  m_en1, m_en2;
    int  m_reg1, m_reg2;
    longint m_data1, m_data2;
    bit  m_ready [NUM_REQ];

    task automatic chk(input string tag, input longint got, input longint exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_outputs();
        chk("en1",   longint'(signal_reg_write_1), longint'(m_en1));
        chk("en2",   longint'(signal_reg_write_2), longint'(m_en2));
        chk("reg1",  longint'(write_reg_1),  longint'(m_reg1));
        chk("reg2",  longint'(write_reg_2),  longint'(m_reg2));
        chk("data1", longint'(write_data_1), m_data1);
        chk("data2", longint'(write_data_2), m_data2);
        chk("stall", longint'(stall_cnt),    longint'(m_stall));
    endtask

    task automatic model_reset();
        m_ptr = 0; m_stall = 0; m_en1 = 0; m_en2 = 0;
        m_reg1 = 0; m_reg2 = 0; m_data1 = 0; m_data2 = 0;
    endtask

    // One clock: check readiness of valid producers, advance the model, check outputs.
    task automatic cycle(input bit do_check);
        int  w1, w2;
        bit  any_stall;
        w1 = -1; w2 = -1; any_stall = 0;
        #1;
        if (!wb_hold && !rst) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                int i;
                i = (m_ptr + k) % NUM_REQ;
                if (req_valid[i] && rg[i] != 0) begin
                    if (w1 < 0) w1 = i;
                    else if (w2 < 0 && rg[i] != rg[w1]) w2 = i;
                end
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            m_ready[i] = req_valid[i] && !wb_hold && !rst && (rg[i] == 0 || i == w1 || i == w2);
            if (req_valid[i] && !m_ready[i]) any_stall = 1;
            if (do_check && req_valid[i])
                chk($sformatf("ready%0d", i), longint'(req_ready[i]), longint'(m_ready[i]));
        end
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            m_en1 = (w1 >= 0);
            m_en2 = (w2 >= 0);
            if (w1 >= 0) begin m_reg1 = rg[w1]; m_data1 = dt[w1]; end
            if (w2 >= 0) begin m_reg2 = rg[w2]; m_data2 = dt[w2]; end
            if (w2 >= 0) m_ptr = (w2 + 1) % NUM_REQ;
            else if (w1 >= 0) m_ptr = (w1 + 1) % NUM_REQ;
            if (any_stall && m_stall != SAT) m_stall++;
        end
        #1;
        if (do_check) chk_outputs();
    endtask

    task automatic clear_reqs();
        req_valid = '0;
        for (int i = 0; i < NUM_REQ; i++) begin rg[i] = '0; dt[i] = '0; end
    endtask

    task automatic do_reset();
        rst = 1'b1; wb_hold = 1'b0; clear_reqs();
        cycle(1);
        cycle(1);
        rst = 1'b0;
    endtask

    int s0;

    initial begin
        rst = 1'b1; wb_hold = 1'b0; clear_reqs();
        model_reset();
        @(posedge clk); #1;
        do_reset();
        chk("rst_stall", longint'(stall_cnt), 0);
        chk("rst_en1", longint'(signal_reg_write_1), 0);

        // Two distinct producers granted together
        req_valid = 4'b0011; rg[0] = 3; dt[0] = 32'h11; rg[1] = 4; dt[1] = 32'h22;
        #1; chk("t1_ready", longint'(req_ready[1:0]), 3);
        cycle(1);
        chk("t1_reg1", longint'(write_reg_1), 3);
        chk("t1_data1", longint'(write_data_1), 32'h11);
        chk("t1_reg2", longint'(write_reg_2), 4);
        chk("t1_data2", longint'(write_data_2), 32'h22);
        chk("t1_ptr", longint'(m_ptr), 2);

        // Four held requesters rotate in pairs
        do_reset();
        req_valid = 4'b1111;
        for (int i = 0; i < NUM_REQ; i++) begin rg[i] = ADDR_W'(8 + i); dt[i] = 32'(100 + i); end
        cycle(1);
        chk("t2_c1", longint'({write_reg_1, write_reg_2}), longint'({5'd8, 5'd9}));
        cycle(1);
        chk("t2_c2", longint'({write_reg_1, write_reg_2}), longint'({5'd10, 5'd11}));
        cycle(1);
        chk("t2_c3", longint'({write_reg_1, write_reg_2}), longint'({5'd8, 5'd9}));
        chk("t2_stall", longint'(stall_cnt), 3);

        // Same destination on two producers
        do_reset();
        req_valid = 4'b0111;
        rg[0] = 5; dt[0] = 32'hA; rg[1] = 6; dt[1] = 32'hB; rg[2] = 5; dt[2] = 32'hC;
        #1; chk("t3_ready", longint'(req_ready[2:0]), 3);
        cycle(1);
        chk("t3_p1", longint'({write_reg_1, write_data_1}), longint'({5'd5, 32'hA}));
        chk("t3_p2", longint'({write_reg_2, write_data_2}), longint'({5'd6, 32'hB}));
        req_valid = 4'b0100;
        cycle(1);
        chk("t3_mem", longint'({signal_reg_write_1, write_reg_1, write_data_1}),
            longint'({1'b1, 5'd5, 32'hC}));
        chk("t3_en2", longint'(signal_reg_write_2), 0);

        // Write to $0 is dropped
        s0 = int'(stall_cnt);
        clear_reqs();
        req_valid = 4'b1000; rg[3] = 0; dt[3] = 32'hFFFF;
        #1; chk("t4_ready", longint'(req_ready[3]), 1);
        cycle(1);
        chk("t4_en", longint'({signal_reg_write_1, signal_reg_write_2}), 0);
        chk("t4_stall", longint'(stall_cnt), longint'(s0));

        // Hold blocks acceptance
        do_reset();
        req_valid = 4'b0001; rg[0] = 7; dt[0] = 32'h77; wb_hold = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1; chk("t5_ready", longint'(req_ready[0]), 0);
            cycle(1);
        end
        chk("t5_stall", longint'(stall_cnt), 3);
        wb_hold = 1'b0;
        cycle(1);
        chk("t5_grant", longint'({signal_reg_write_1, write_reg_1}), longint'({1'b1, 5'd7}));

        // Counter saturation
        wb_hold = 1'b1;
        for (int c = 0; c < (1 << CNT_W) + 5; c++) cycle(0);
        chk("t6_sat", longint'(stall_cnt), SAT);
        chk_outputs();

        // Reset with a grant pending
        wb_hold = 1'b0;
        req_valid = 4'b0011; rg[0] = 3; dt[0] = 32'h33; rg[1] = 4; dt[1] = 32'h44;
        cycle(1);
        rst = 1'b1;
        #1;
        chk("t6_pending", longint'({signal_reg_write_1, signal_reg_write_2}), 3);
        chk("t6_rst_ready", longint'(req_ready), 0);
        cycle(1);
        chk("t6_zero", longint'({signal_reg_write_1, signal_reg_write_2, write_reg_1,
                                 write_reg_2, stall_cnt}), 0);
        chk("t6_zero_d", longint'({write_data_1, write_data_2}), 0);
        cycle(1);
        rst = 1'b0;

        // Randomized traffic with stable-until-accepted producers
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!(req_valid[i] && !m_ready[i]) || rst) begin
                    req_valid[i] = ($urandom_range(0, 3) != 0);
                    rg[i] = ADDR_W'($urandom_range(0, 4));
                    dt[i] = $urandom;
                end
            end
            wb_hold = ($urandom_range(0, 9) == 0);
            rst     = ($urandom_range(0, 99) == 0);
            cycle(1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
